// File: rtl/seg7_scan_mux.sv
// ----------------------------------------------------------------------------
// seg7_scan_mux
//
// Time-multiplexed driver for a common-anode style 7-segment display bank.
// A prescaler divides clk down to one digit slot every DIV cycles; the digit
// index walks 0..NUM_DIGITS-1 and the registered seg/dp/an outputs follow it.
// New values are captured into a shadow register on load and promoted to the
// display register only at the frame boundary, so a frame never mixes old
// and new digits.
//
// Parameters
//   NUM_DIGITS : number of multiplexed digits (2..8)
//   DIV        : clock cycles per digit slot (>= 2)
//   HEX_MODE   : 1 = show nibbles 10..15 as A,b,C,d,E,F; 0 = blank them
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   load       in   capture value/dp_in this cycle
//   value      in   4*NUM_DIGITS nibbles, nibble 0 is least significant
//   dp_in      in   decimal point per digit, active-high
//   blank_lz   in   leading-zero blanking enable (live, not shadowed)
//   seg        out  {a,b,c,d,e,f,g}, active-low
//   dp         out  decimal point, active-low
//   an         out  digit enables, active-low, one-hot-low while scanning
//   frame_done out  one-cycle pulse after the index wraps to 0
// ----------------------------------------------------------------------------
module seg7_scan_mux #(
    parameter int NUM_DIGITS = 4,
    parameter int DIV        = 50000,
    parameter int HEX_MODE   = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic                      blank_lz,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      frame_done
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Scan has not yet started after reset (all anodes off) or is running.
    typedef enum logic {
        ST_IDLE,
        ST_SCAN
    } state_t;

    state_t state, state_nx;

    logic [CW-1:0]             cnt;
    logic                      tick;
    logic [IW-1:0]             idx;
    logic [IW-1:0]             idx_nx;
    logic                      last;
    logic                      start;
    logic                      wrap;
    logic                      frame_start;

    logic [4*NUM_DIGITS-1:0]   shadow_val;
    logic [NUM_DIGITS-1:0]     shadow_dp;
    logic [4*NUM_DIGITS-1:0]   disp_val;
    logic [NUM_DIGITS-1:0]     disp_dp;
    logic [4*NUM_DIGITS-1:0]   disp_val_nx;
    logic [NUM_DIGITS-1:0]     disp_dp_nx;

    logic [3:0]                nib;
    logic                      blank_digit;
    logic [6:0]                seg_nx;
    logic [NUM_DIGITS-1:0]     an_nx;

    // ------------------------------------------------------------------
    // Segment decode, active-low {a,b,c,d,e,f,g}
    // ------------------------------------------------------------------
    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] d;
        d = SEG_BLANK;
        case (n)
            4'h0: d = 7'b0000001;
            4'h1: d = 7'b1001111;
            4'h2: d = 7'b0010010;
            4'h3: d = 7'b0000110;
            4'h4: d = 7'b1001100;
            4'h5: d = 7'b0100100;
            4'h6: d = 7'b0100000;
            4'h7: d = 7'b0001111;
            4'h8: d = 7'b0000000;
            4'h9: d = 7'b0001100;
            4'hA: d = (HEX_MODE != 0) ? 7'b0001000 : SEG_BLANK;
            4'hB: d = (HEX_MODE != 0) ? 7'b1100000 : SEG_BLANK;
            4'hC: d = (HEX_MODE != 0) ? 7'b0110001 : SEG_BLANK;
            4'hD: d = (HEX_MODE != 0) ? 7'b1000010 : SEG_BLANK;
            4'hE: d = (HEX_MODE != 0) ? 7'b0110000 : SEG_BLANK;
            4'hF: d = (HEX_MODE != 0) ? 7'b0111000 : SEG_BLANK;
            default: d = SEG_BLANK;
        endcase
        return d;
    endfunction

    // ------------------------------------------------------------------
    // Prescaler
    // ------------------------------------------------------------------
    assign tick = (cnt == CW'(DIV - 1));

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values of the others, independent of order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Scan state and digit index
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // NOTE: every signal written here gets a default first, so no path
    // through the block can leave a value unassigned and infer a latch.
    always_comb begin
        state_nx = state;
        if (state == ST_IDLE && tick) begin
            state_nx = ST_SCAN;
        end
    end

    assign last  = (idx == IW'(NUM_DIGITS - 1));
    // The first tick after reset lights digit 0 without advancing; it is
    // also where the first frame's contents are taken from the shadow.
    assign start = tick && (state == ST_IDLE);
    assign wrap  = tick && (state == ST_SCAN) && last;
    assign frame_start = start || wrap;

    always_comb begin
        idx_nx = idx;
        if (start || wrap) begin
            idx_nx = '0;
        end else if (tick) begin
            idx_nx = idx + IW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= '0;
            frame_done <= 1'b0;
        end else begin
            idx        <= idx_nx;
            frame_done <= wrap;
        end
    end

    // ------------------------------------------------------------------
    // Shadow and display registers
    // ------------------------------------------------------------------
    // A load coinciding with the frame boundary bypasses the shadow so the
    // new value shows in the very next frame.
    always_comb begin
        disp_val_nx = disp_val;
        disp_dp_nx  = disp_dp;
        if (frame_start) begin
            disp_val_nx = load ? value : shadow_val;
            disp_dp_nx  = load ? dp_in : shadow_dp;
        end
    end

    // NOTE: these data registers are reset because a reset must discard a
    // pending load and show zeros, not stale contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_val <= '0;
            shadow_dp  <= '0;
            disp_val   <= '0;
            disp_dp    <= '0;
        end else begin
            if (load) begin
                shadow_val <= value;
                shadow_dp  <= dp_in;
            end
            disp_val <= disp_val_nx;
            disp_dp  <= disp_dp_nx;
        end
    end

    // ------------------------------------------------------------------
    // Output decode for the digit that becomes current on this tick
    // ------------------------------------------------------------------
    always_comb begin
        nib         = disp_val_nx[4*int'(idx_nx) +: 4];
        blank_digit = 1'b0;
        // Digit i>0 is a leading zero when nibbles i..N-1 are all zero.
        if (blank_lz && (idx_nx != '0)) begin
            blank_digit = 1'b1;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (i >= int'(idx_nx) && disp_val_nx[4*i +: 4] != 4'h0) begin
                    blank_digit = 1'b0;
                end
            end
        end
        seg_nx        = blank_digit ? SEG_BLANK : decode(nib);
        an_nx         = '1;
        an_nx[idx_nx] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg <= SEG_BLANK;
            dp  <= 1'b1;
            an  <= '1;
        end else if (tick) begin
            seg <= seg_nx;
            dp  <= ~disp_dp_nx[idx_nx];
            an  <= an_nx;
        end
    end

endmodule

// File: doc/seg7_scan_mux.md
SEG7_SCAN_MUX -- requirements
Module: seg7_scan_mux

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of multiplexed digits (legal range 2..8) SHALL be supported.
REQ-002 Parameter DIV, default 50000, clock cycles per digit slot (legal minimum 2) SHALL be supported.
REQ-003 Parameter HEX_MODE, default 0; 1 SHALL decode nibbles 10..15 as A,b,C,d,E,F, and 0 SHALL blank them.
REQ-004 Ports SHALL be exactly as follows; one clock; reset asynchronous, active-low:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- load  in  1  capture value/dp_in this cycle
- value  in  4*NUM_DIGITS  BCD/hex nibbles; nibble i = digit i; digit 0 is least significant
- dp_in  in  NUM_DIGITS  decimal point per digit, active-high
- blank_lz  in  1  leading-zero blanking enable
- seg  out  7  {a,b,c,d,e,f,g}, active-low
- dp  out  1  decimal point, active-low
- an  out  NUM_DIGITS  digit enables, active-low, one-hot-low when scanning
- frame_done  out  1  one-cycle pulse at end of each full scan

Function
REQ-005 Prescaler SHALL count 0..DIV-1, wrap to 0, and assert internal tick in the cycle the count equals DIV-1.
REQ-006 Digit index SHALL advance by 1 on each tick and wrap from NUM_DIGITS-1 to 0.
REQ-007 frame_done SHALL be high for exactly the one cycle after the index wraps to 0 (registered with index).
REQ-008 load SHALL write value/dp_in into a shadow register on the same clk edge.
REQ-009 Display register SHALL copy from shadow only at the index wrap, so no frame mixes old and new digits.
REQ-010 If load coincides with the wrap, the display register SHALL take value/dp_in directly and the shadow SHALL also capture them.
REQ-011 Multiple loads within one frame SHALL cause only the last load to be displayed.
REQ-012 seg, dp and an SHALL be registered and update in the same cycle as the index: an[i]=0 only for the current index i.
REQ-013 The decode SHALL produce:
- 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
- 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0001100
REQ-014 With HEX_MODE=1, the decode SHALL produce A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
REQ-015 With HEX_MODE=0, nibbles 10..15 SHALL produce seg=1111111.
REQ-016 With blank_lz=1, digit i>0 SHALL show seg=1111111 when it and every more-significant nibble are 0.
REQ-017 Digit 0 SHALL never be leading-zero blanked.
REQ-018 dp SHALL equal ~dp_display[index], and a blanked digit SHALL still show its dp.
REQ-019 blank_lz SHALL be sampled live, not shadowed, and take effect on the next index update.

Reset
REQ-020 While rst_n=0, the block SHALL hold prescaler=0, index=0, and shadow/display value and dp=0.
REQ-021 While rst_n=0, outputs SHALL be seg=1111111, dp=1, an=all ones, frame_done=0.
REQ-022 After reset release, an SHALL stay all ones until the first tick, then enable digit 0.
REQ-023 Reset asserted mid-frame SHALL take effect immediately (asynchronously) and discard any pending shadow contents.

Verification (NUM_DIGITS=4, DIV=4 unless stated)
REQ-024 Reset release, no load -> first tick at cycle 4; an=1110, seg=0000001, dp=1; an cycles 1101,1011,0111,1110 every 4 cycles.
REQ-025 Load value=16'h1234, dp_in=0100 mid-frame -> old digits kept until the wrap; next frame digit 0 seg=1001100, digit 2 seg=0010010 with dp=0.
REQ-026 Load 16'h0050 with blank_lz=1:
- digits 3 and 2 -> seg=1111111
- digit 1 -> seg=0100100
- digit 0 -> seg=0000001
REQ-027 Load 16'hABCF with HEX_MODE=1 -> seg 0111000, 0110001, 1100000, 0001000 for digits 0..3; with HEX_MODE=0 -> all 1111111.
REQ-028 load pulsed on the wrap cycle with 16'h9999 -> the very next frame shows 0001100 on all digits; frame_done pulses once per 16 cycles.
REQ-029 rst_n dropped mid-scan after loading 16'h8888 -> outputs go to reset values within the same cycle; after release, the display shows 0000.
